// File: rtl/sample_framer.sv
// sample_framer
//
// Decimating sample source for the audio filter chain. Sums DEC accepted
// input words, emits one arithmetically shifted 32-bit signed sample per
// frame, and produces a sample clock (outsclk) for the downstream stages.
// y is updated on the edge that completes a frame. outsclk rises on the
// following edge and stays high for HIGH_CYC cycles, so y is stable across
// both outsclk edges.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   din        in   IN_W-bit signed input sample
//   din_valid  in   din accepted on this posedge when high
//   sync       in   synchronous frame restart (y, frame_cnt, pulse unaffected)
//   y          out  32-bit signed averaged sample, registered
//   outsclk    out  generated sample clock, registered
//   frame_cnt  out  16-bit count of emitted samples, wraps
module sample_framer #(
    parameter int DEC      = 64,
    parameter int LOG2_DEC = 6,
    parameter int SHIFT    = 6,
    parameter int IN_W     = 16,
    parameter int HIGH_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] din,
    input  logic                   din_valid,
    input  logic                   sync,
    output logic signed [31:0]     y,
    output logic                   outsclk,
    output logic [15:0]            frame_cnt
);

    localparam int CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEC - 1);
    localparam logic [7:0]       HIGH_LAST = 8'(HIGH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2
    } state_t;

    logic signed [31:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [31:0] y_q, y_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    state_t             state_q, state_d;
    logic [7:0]         hcnt_q, hcnt_d;
    logic               outsclk_q, outsclk_d;

    logic signed [31:0] din_ext;
    logic signed [31:0] sum;
    logic               frame_done;

    assign din_ext    = {{(32 - IN_W){din[IN_W-1]}}, din};
    assign sum        = acc_q + din_ext;
    // sync takes priority: a sample arriving with sync starts a new frame
    // rather than completing the old one.
    assign frame_done = din_valid && !sync && (cnt_q == CNT_LAST);

    // Accumulator, sample counter and output sample
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        if (sync) begin
            if (din_valid) begin
                acc_d = din_ext;
                cnt_d = CNT_W'(1);
            end else begin
                acc_d = '0;
                cnt_d = '0;
            end
        end else if (din_valid) begin
            if (frame_done) begin
                // >>> on a signed operand floors toward -inf
                y_d         = sum >>> SHIFT;
                acc_d       = '0;
                cnt_d       = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Pulse FSM. A frame completing outside IDLE cannot happen because
    // completions are at least DEC edges apart and a pulse needs
    // HIGH_CYC + 1 edges, so IDLE is the only state that reacts to it.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            S_IDLE: begin
                if (frame_done) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_HIGH;
                hcnt_d  = 8'd0;
            end
            S_HIGH: begin
                if (hcnt_q == HIGH_LAST) begin
                    state_d = S_IDLE;
                    hcnt_d  = 8'd0;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                hcnt_d  = 8'd0;
            end
        endcase
        // outsclk is registered from the next state so it is glitch-free
        // and aligned with the HIGH state.
        outsclk_d = (state_d == S_HIGH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            outsclk_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            outsclk_q   <= outsclk_d;
        end
    end

    assign y         = y_q;
    assign outsclk   = outsclk_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sample_framer.sv
// Directed testbench for sample_framer: one DEC=4 instance (SHIFT=2,
// HIGH_CYC=1) and one DEC=64 instance (SHIFT=6, HIGH_CYC=4).
module tb_sample_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEC=4 instance
    logic               rst4, v4, sync4;
    logic signed [15:0] din4;
    logic signed [31:0] y4;
    logic               sclk4;
    logic [15:0]        fc4;

    // DEC=64 instance
    logic               rst64, v64, sync64;
    logic signed [15:0] din64;
    logic signed [31:0] y64;
    logic               sclk64;
    logic [15:0]        fc64;

    int n_vec = 0;
    int n_err = 0;

    logic        sclk4_prev, sclk64_prev;
    logic [15:0] fc4_prev, fc64_prev;

    sample_framer #(.DEC(4), .LOG2_DEC(2), .SHIFT(2), .IN_W(16), .HIGH_CYC(1)) u_dec4 (
        .clk(clk), .rst(rst4), .din(din4), .din_valid(v4), .sync(sync4),
        .y(y4), .outsclk(sclk4), .frame_cnt(fc4)
    );

    sample_framer #(.DEC(64), .LOG2_DEC(6), .SHIFT(6), .IN_W(16), .HIGH_CYC(4)) u_dec64 (
        .clk(clk), .rst(rst64), .din(din64), .din_valid(v64), .sync(sync64),
        .y(y64), .outsclk(sclk64), .frame_cnt(fc64)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it. A frame
    // completion (frame_cnt step) must never land while a pulse is high.
    task automatic step();
        sclk4_prev  = sclk4;
        sclk64_prev = sclk64;
        fc4_prev    = fc4;
        fc64_prev   = fc64;
        @(posedge clk);
        #1;
        if (!rst4 && fc4 != fc4_prev)
            chk("dec4_done_in_high", 32'(sclk4_prev), 32'd0);
        if (!rst64 && fc64 != fc64_prev)
            chk("dec64_done_in_high", 32'(sclk64_prev), 32'd0);
    endtask

    task automatic put4(input logic signed [15:0] d);
        din4 = d;
        v4   = 1'b1;
        step();
    endtask

    logic signed [15:0] gap_vals [4];

    initial begin
        rst4 = 1'b0; v4 = 1'b1; sync4 = 1'b0; din4 = 16'sh1234;
        rst64 = 1'b0; v64 = 1'b1; sync64 = 1'b0; din64 = 16'sh1234;
        #1;
        rst4 = 1'b1; rst64 = 1'b1;

        // Reset held 3 cycles with valid data present
        repeat (3) step();
        chk("rst_y4", y4, 32'd0);
        chk("rst_sclk4", 32'(sclk4), 32'd0);
        chk("rst_fc4", 32'(fc4), 32'd0);
        chk("rst_y64", y64, 32'd0);
        chk("rst_sclk64", 32'(sclk64), 32'd0);
        chk("rst_fc64", 32'(fc64), 32'd0);
        $display("reset: y4=%h sclk4=%b fc4=%0d", y4, sclk4, fc4);

        // Release: 4 samples of 0x1234, rise DEC+1 edges after release
        rst4 = 1'b0;
        repeat (3) step();
        chk("rel_early_sclk4", 32'(sclk4), 32'd0);
        step();
        chk("rel_y4", y4, 32'h0000_1234);
        chk("rel_fc4", 32'(fc4), 32'd1);
        chk("rel_edge4_sclk4", 32'(sclk4), 32'd0);
        v4 = 1'b0;
        step();
        chk("rel_edge5_sclk4", 32'(sclk4), 32'd1);
        step();
        chk("rel_edge6_sclk4", 32'(sclk4), 32'd0);
        $display("release frame: y4=%h fc4=%0d", y4, fc4);

        // Basic frame 100,200,300,400 -> 250
        put4(16'sd100); put4(16'sd200); put4(16'sd300); put4(16'sd400);
        chk("basic_y", y4, 32'd250);
        chk("basic_fc", 32'(fc4), 32'd2);
        chk("basic_sclk_n", 32'(sclk4), 32'd0);
        v4 = 1'b0;
        step();
        chk("basic_sclk_n1", 32'(sclk4), 32'd1);
        step();
        chk("basic_sclk_n2", 32'(sclk4), 32'd0);
        $display("basic frame: y4=%0d fc4=%0d", y4, fc4);

        // Negative rounding: -5 >>> 2 = -2
        put4(-16'sd1); put4(-16'sd1); put4(-16'sd1); put4(-16'sd2);
        chk("neg_y", y4, 32'hFFFF_FFFE);
        chk("neg_fc", 32'(fc4), 32'd3);
        v4 = 1'b0;
        step(); step();
        $display("negative frame: y4=%h fc4=%0d", y4, fc4);

        // Gapped valid: every 3rd cycle, 0x7FFF on invalid cycles
        gap_vals[0] = 16'sd100; gap_vals[1] = 16'sd200;
        gap_vals[2] = 16'sd300; gap_vals[3] = 16'sd400;
        for (int i = 0; i < 4; i++) begin
            v4 = 1'b0; din4 = 16'sh7FFF;
            step(); step();
            if (i == 3) chk("gap_fc_before", 32'(fc4), 32'd3);
            put4(gap_vals[i]);
        end
        chk("gap_y", y4, 32'd250);
        chk("gap_fc", 32'(fc4), 32'd4);
        v4 = 1'b0; din4 = 16'sh7FFF;
        step();
        chk("gap_sclk_n1", 32'(sclk4), 32'd1);
        step();
        chk("gap_sclk_n2", 32'(sclk4), 32'd0);
        $display("gapped frame: y4=%0d fc4=%0d", y4, fc4);

        // Sync: 1000,1000 discarded; sync with 10 starts new frame
        put4(16'sd1000); put4(16'sd1000);
        sync4 = 1'b1;
        put4(16'sd10);
        sync4 = 1'b0;
        put4(16'sd10); put4(16'sd10);
        chk("sync_fc_before", 32'(fc4), 32'd4);
        put4(16'sd10);
        chk("sync_y", y4, 32'd10);
        chk("sync_fc", 32'(fc4), 32'd5);
        // sync during SETUP must not disturb the pulse, y or frame_cnt
        v4 = 1'b0; sync4 = 1'b1;
        step();
        sync4 = 1'b0;
        chk("sync_pulse_sclk", 32'(sclk4), 32'd1);
        chk("sync_pulse_y", y4, 32'd10);
        chk("sync_pulse_fc", 32'(fc4), 32'd5);
        $display("sync frame: y4=%0d fc4=%0d sclk4=%b", y4, fc4, sclk4);

        // Asynchronous reset while outsclk is high (no clk edge in between)
        rst4 = 1'b1;
        #1;
        chk("arst_sclk", 32'(sclk4), 32'd0);
        chk("arst_fc", 32'(fc4), 32'd0);
        chk("arst_y", y4, 32'd0);
        $display("async reset mid-pulse: sclk4=%b fc4=%0d", sclk4, fc4);
        step();
        rst4 = 1'b0;

        // Full scale, DEC=64: 64 x -32768
        din64 = -16'sd32768; v64 = 1'b1;
        rst64 = 1'b0;
        repeat (64) step();
        chk("fs_neg_y", y64, 32'hFFFF_8000);
        chk("fs_neg_fc", 32'(fc64), 32'd1);
        chk("fs_neg_sclk", 32'(sclk64), 32'd0);
        $display("full scale negative: y64=%h fc64=%0d", y64, fc64);

        // 64 x 32767 with continuous valid; check pulse shape and period
        din64 = 16'sd32767;
        for (int k = 1; k <= 65; k++) begin
            step();
            if (k == 1)  chk("fs_rise", 32'(sclk64), 32'd1);
            if (k == 4)  chk("fs_high_last", 32'(sclk64), 32'd1);
            if (k == 5)  chk("fs_fall", 32'(sclk64), 32'd0);
            if (k == 63) chk("fs_y_stable", y64, 32'hFFFF_8000);
            if (k == 64) begin
                chk("fs_pos_y", y64, 32'd32767);
                chk("fs_pos_fc", 32'(fc64), 32'd2);
                chk("fs_pos_sclk", 32'(sclk64), 32'd0);
            end
            if (k == 65) chk("fs_period_rise", 32'(sclk64), 32'd1);
        end
        v64 = 1'b0;
        $display("full scale positive: y64=%0d fc64=%0d", y64, fc64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_framer.md
# sample_framer

Decimating sample source that drives the audio filter chain's sample interface. It accumulates DEC valid ADC words on the system clock and emits one 32-bit signed averaged sample. For each emitted sample it generates the sample clock `outsclk`, which the downstream biquad stages use as their `insclk`. It is the transmitting end of the `y`/sample-clock interface: `y` is stable before each `outsclk` rising edge, and `outsclk` falls before `y` changes again.

## Interface
- `DEC`, 64: samples per output frame; power of two, 2..65536.
- `LOG2_DEC`, 6: log2(DEC); must match DEC.
- `SHIFT`, 6: arithmetic right shift applied to the frame sum; 0..LOG2_DEC.
- `IN_W`, 16: input sample width; IN_W + LOG2_DEC ≤ 32.
- `HIGH_CYC`, 4: `outsclk` high time in clk cycles; 1..255; DEC ≥ HIGH_CYC + 2.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  IN_W  signed input sample.
- `din_valid`  in  1  `din` is accepted on this posedge when high.
- `sync`  in  1  synchronous frame restart.
- `y`  out  32  signed output sample, registered.
- `outsclk`  out  1  generated sample clock, registered.
- `frame_cnt`  out  16  count of emitted samples, wraps.

## Operation
- Accumulator `acc` is 32-bit signed; `din` is sign-extended. Sample counter `cnt` runs 0..DEC-1.
- On an accepted sample:
  - If `cnt` < DEC-1: `acc += din`, `cnt += 1`.
  - If `cnt` = DEC-1 (frame complete): `y <= (acc + din) >>> SHIFT`, an arithmetic shift that floors toward −inf; `acc <= 0`, `cnt <= 0`, `frame_cnt += 1` (0xFFFF wraps to 0); pulse FSM goes to SETUP.
- Overflow cannot occur given the width constraint, so there is no saturation.
- `din` is ignored when `din_valid` is low.
- `sync` high: `acc <= 0`, `cnt <= 0`. If `din_valid` is also high, that sample becomes the first sample of the new frame (`acc <= din`, `cnt <= 1`).
- `sync` does not affect `y`, `frame_cnt` or a pulse already in progress.
- Pulse FSM:
  - IDLE: `outsclk` = 0. A frame-complete event moves it to SETUP.
  - SETUP: `outsclk` = 0, lasts one cycle so `y` is settled; then HIGH with `hcnt` = 0.
  - HIGH: `outsclk` = 1. `hcnt` increments; when `hcnt` = HIGH_CYC-1, go to IDLE.
- A frame-complete event outside IDLE is unreachable under DEC ≥ HIGH_CYC+2, because at least DEC edges separate completions. It needs no handling; the bench asserts it never occurs.

## Timing
- Reset values: `y` = 0, `outsclk` = 0, `frame_cnt` = 0, `acc` = 0, `cnt` = 0, FSM IDLE, `hcnt` = 0.
- Reset asserted mid-pulse drives `outsclk` low immediately (asynchronous). The downstream falling edge this produces is accepted. Any partial frame is discarded.
- Let edge n be the posedge accepting the DEC-th sample.
  - `y` and `frame_cnt` update at edge n.
  - `outsclk` rises at edge n+1 and falls at edge n+1+HIGH_CYC.
- Latency from the last sample of a frame to the `outsclk` rising edge is 2 edges (edge n, then edge n+1).
- `y` is constant from edge n until at least edge n+DEC, so it is stable across both `outsclk` edges.
- With `din_valid` continuously high, `outsclk` period = DEC clk cycles.

## Test plan
- Reset: hold `rst` for 3 cycles with `din_valid` = 1 and `din` = 0x1234 → `y` = 0, `outsclk` = 0, `frame_cnt` = 0. First `outsclk` rise occurs DEC+1 edges after release.
- Basic frame (DEC=4, LOG2_DEC=2, SHIFT=2, HIGH_CYC=1): `din` 100, 200, 300, 400 on consecutive cycles → `y` = 250 at the 4th edge, `outsclk` high for exactly one cycle starting at the next edge, `frame_cnt` = 1.
- Negative rounding (same parameters): −1, −1, −1, −2 → sum −5, `y` = −2 (0xFFFFFFFE).
- Gapped valid: `din_valid` high every 3rd cycle, `din` = 0x7FFF while invalid, valid values 100..400 → `y` = 250, `outsclk` rise 1 edge after the 4th valid sample.
- Full scale (DEC=64, SHIFT=6): 64 × −32768 → `y` = 0xFFFF8000. 64 × 32767 → `y` = 32767. `outsclk` period = 64 cycles.
- Sync and reset (DEC=4): two samples of 1000, then `sync` with `din_valid` and `din` = 10, then three more samples of 10 → `y` = 10. Asserting `rst` during HIGH → `outsclk` = 0 with no clk edge needed, `frame_cnt` = 0.
